// File: rtl/scoreboard_pkg.sv
// Shared definitions for the button-conditioning block.
// Holds the default channel count, the default timing constants and the
// per-channel debounce state encoding.
package scoreboard_pkg;

    localparam int unsigned NBTN             = 9;
    localparam int unsigned PRESCALE_DEF     = 50000;
    localparam int unsigned DB_TICKS_DEF     = 8;
    localparam int unsigned REPEAT_DELAY_DEF = 500;
    localparam int unsigned REPEAT_RATE_DEF  = 100;

    typedef enum logic [1:0] {
        LOW     = 2'd0,
        PEND_HI = 2'd1,
        HIGH    = 2'd2,
        PEND_LO = 2'd3
    } btn_state_t;

endpackage

// File: rtl/sb_debounce_ch.sv
// One debounced button channel: 2-flop synchronizer, LOW/PEND_HI/HIGH/PEND_LO
// state machine with a debounce tick counter, and registered level/press/release.
// Optional auto-repeat of the press pulse while held: SCOREBOARD_BTN_REPEAT_EN.
//
// Ports:
//   clk_i      clock
//   rst_i      synchronous active-high reset
//   raw_i      asynchronous pad input, active-high
//   tick_i     shared debounce tick, one cycle wide
//   level_o    debounced level (registered)
//   press_o    one-cycle press pulse (registered)
//   release_o  one-cycle release pulse (registered)
//   press_c    next-cycle value of press_o, for the top-level OR register
module sb_debounce_ch
    import scoreboard_pkg::*;
#(
    parameter int unsigned DB_TICKS     = DB_TICKS_DEF
`ifdef SCOREBOARD_BTN_REPEAT_EN
   ,parameter int unsigned REPEAT_DELAY = REPEAT_DELAY_DEF
   ,parameter int unsigned REPEAT_RATE  = REPEAT_RATE_DEF
`endif
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    input  logic tick_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic press_c
);

    localparam int unsigned CNT_W = $clog2(DB_TICKS + 1);

    logic             sync1_q, sync2_q;
    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             rise_c;

`ifdef SCOREBOARD_BTN_REPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             rpt_fire;

    // Ticks-to-next-repeat countdown; reloaded whenever the channel is not settled HIGH.
    always_comb begin
        rpt_d    = rpt_q;
        rpt_fire = 1'b0;
        if (state_q != HIGH) begin
            rpt_d = RPT_W'(REPEAT_DELAY);
        end else if (sync2_q && tick_i) begin
            if (rpt_q == RPT_W'(1)) begin
                rpt_fire = 1'b1;
                rpt_d    = RPT_W'(REPEAT_RATE);
            end else begin
                rpt_d = rpt_q - RPT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rpt_q <= '0;
        end else begin
            rpt_q <= rpt_d;
        end
    end
`endif

    // State, counter and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            state_q   <= LOW;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= raw_i;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // Debounce FSM: any synchronized change back to the settled level wins over a tick.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            LOW: begin
                if (sync2_q) begin
                    state_d = PEND_HI;
                    cnt_d   = '0;
                end
            end
            PEND_HI: begin
                if (!sync2_q) begin
                    state_d = LOW;
                end else if (tick_i) begin
                    if (cnt_q == CNT_W'(DB_TICKS - 1)) begin
                        state_d = HIGH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            HIGH: begin
                if (!sync2_q) begin
                    state_d = PEND_LO;
                    cnt_d   = '0;
                end
            end
            PEND_LO: begin
                if (sync2_q) begin
                    state_d = HIGH;
                end else if (tick_i) begin
                    if (cnt_q == CNT_W'(DB_TICKS - 1)) begin
                        state_d = LOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = LOW;
                cnt_d   = '0;
            end
        endcase
    end

    // Level and edge pulses, aligned with the registered level.
    always_comb begin
        level_d   = (state_d == HIGH) || (state_d == PEND_LO);
        rise_c    = level_d & ~level_q;
        release_d = ~level_d & level_q;
`ifdef SCOREBOARD_BTN_REPEAT_EN
        press_d   = rise_c | rpt_fire;
`else
        press_d   = rise_c;
`endif
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign press_c   = press_d;

endmodule

// File: rtl/scoreboard_btn_cond.sv
// Button conditioning for NBTN pads: one shared debounce prescaler feeding
// NBTN independent debounce channels, plus a registered any-press flag.
// Optional press auto-repeat while held: define SCOREBOARD_BTN_REPEAT_EN.
//
// Ports:
//   wb_clk_i     sole clock
//   wb_rst_i     synchronous active-high reset
//   btn_raw      asynchronous pad inputs, active-high
//   btn_level    debounced levels
//   btn_press    one-cycle pulse per accepted press
//   btn_release  one-cycle pulse per accepted release
//   press_any    OR of btn_press, registered to coincide with it
module scoreboard_btn_cond
    import scoreboard_pkg::*;
#(
    parameter int unsigned NBTN         = scoreboard_pkg::NBTN,
    parameter int unsigned PRESCALE     = PRESCALE_DEF,
    parameter int unsigned DB_TICKS     = DB_TICKS_DEF,
    parameter int unsigned REPEAT_DELAY = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_RATE  = REPEAT_RATE_DEF
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic [NBTN-1:0] btn_raw,
    output logic [NBTN-1:0] btn_level,
    output logic [NBTN-1:0] btn_press,
    output logic [NBTN-1:0] btn_release,
    output logic            press_any
);

    localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0] ps_q, ps_d;
    logic            tick;
    logic [NBTN-1:0] press_nxt;
    logic            press_any_q;

    // Shared prescaler: 0..PRESCALE-1, tick on the last count.
    assign tick = (ps_q == PS_W'(PRESCALE - 1));
    assign ps_d = tick ? '0 : ps_q + PS_W'(1);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ps_q        <= '0;
            press_any_q <= 1'b0;
        end else begin
            ps_q        <= ps_d;
            press_any_q <= |press_nxt;
        end
    end

    for (genvar i = 0; i < int'(NBTN); i++) begin : g_ch
        sb_debounce_ch #(
            .DB_TICKS     (DB_TICKS)
`ifdef SCOREBOARD_BTN_REPEAT_EN
           ,.REPEAT_DELAY (REPEAT_DELAY)
           ,.REPEAT_RATE  (REPEAT_RATE)
`endif
        ) u_ch (
            .clk_i     (wb_clk_i),
            .rst_i     (wb_rst_i),
            .raw_i     (btn_raw[i]),
            .tick_i    (tick),
            .level_o   (btn_level[i]),
            .press_o   (btn_press[i]),
            .release_o (btn_release[i]),
            .press_c   (press_nxt[i])
        );
    end

    assign press_any = press_any_q;

endmodule

// File: doc/scoreboard_btn_cond.md
SCOREBOARD_BTN_COND -- requirements
Module: scoreboard_btn_cond

Interface
REQ-001 SHALL have parameter NBTN, default 9, number of button channels (io_in[37:29]).
REQ-002 SHALL have parameter PRESCALE, default 50000, wb_clk_i cycles per debounce tick.
REQ-003 SHALL have parameter DB_TICKS, default 8, consecutive stable ticks to accept a level change.
REQ-004 SHALL have parameters REPEAT_DELAY, default 500, and REPEAT_RATE, default 100, both in ticks; used only under REQ-021.
REQ-005 SHALL have one clock and a synchronous, active-high reset: wb_clk_i in, wb_rst_i in.
REQ-006 SHALL have ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- btn_raw  in  NBTN  asynchronous pad inputs, active-high.
- btn_level  out  NBTN  debounced level.
- btn_press  out  NBTN  one-cycle pulse per accepted press.
- btn_release  out  NBTN  one-cycle pulse per accepted release.
- press_any  out  1  registered OR of btn_press, same cycle.

Function
REQ-007 SHALL pass each btn_raw bit through a 2-flop synchronizer before any other logic.
REQ-008 SHALL run one shared prescaler counting 0..PRESCALE-1 and wrapping to 0, asserting internal tick for one cycle at PRESCALE-1.
REQ-009 Each channel SHALL be a 4-state FSM: LOW, PEND_HI, HIGH, PEND_LO, with a tick counter of width clog2(DB_TICKS+1).
REQ-010 LOW: sync=1 -> PEND_HI, counter=0. HIGH: sync=0 -> PEND_LO, counter=0.
REQ-011 PEND_HI: sync=0 -> LOW with no outputs. Otherwise counter increments on each tick; on the DB_TICKS-th tick -> HIGH.
REQ-012 PEND_LO SHALL mirror REQ-011 (sync=1 -> HIGH, DB_TICKS-th tick -> LOW).
REQ-013 btn_level SHALL be 1 exactly in HIGH and PEND_LO.
REQ-014 btn_press[i] SHALL be high for exactly the first cycle btn_level[i] reads 1; btn_release[i] for the first cycle it reads 0.
REQ-015 A raw edge held stable SHALL change btn_level no earlier than (DB_TICKS-1)*PRESCALE and no later than DB_TICKS*PRESCALE+4 cycles after the edge.
REQ-016 Pulses shorter than (DB_TICKS-1)*PRESCALE cycles SHALL produce no level change and no pulse.
REQ-017 Channels SHALL be independent; simultaneous events on several channels SHALL pulse in the same cycle.
REQ-018 A tick coinciding with a sync change SHALL be governed by the sync change: a sync change returns the channel to the stable state regardless of the tick.

Reset
REQ-019 While wb_rst_i=1 at a clock edge:
- synchronizers, prescaler and counters SHALL clear to 0;
- FSMs SHALL enter LOW;
- all outputs SHALL be 0.
REQ-020 Reset mid-PEND or in HIGH SHALL emit no release pulse. A button held through reset SHALL be debounced as a new press.

Configuration
REQ-021 With SCOREBOARD_BTN_REPEAT_EN defined, HIGH SHALL re-pulse btn_press REPEAT_DELAY ticks after entry and then every REPEAT_RATE ticks while HIGH. Without it, no repeat logic or counter SHALL exist, and exactly one press pulse per accepted press.

Structure
REQ-022 Package scoreboard_pkg SHALL hold NBTN, default PRESCALE/DB_TICKS/REPEAT_* constants and the btn_state_t enum (LOW, PEND_HI, HIGH, PEND_LO).
REQ-023 Sub-module sb_debounce_ch SHALL implement one channel (synchronizer, FSM, counter, pulses), instantiated NBTN times. The prescaler SHALL sit in the top module.

Verification (PRESCALE=4, DB_TICKS=3, REPEAT_DELAY=5, REPEAT_RATE=2)
REQ-024 Clean press: btn_raw[0] 0->1 held 40 cycles -> one btn_press[0] pulse, 8..16 cycles after the edge; btn_level[0]=1; all other outputs 0.
REQ-025 Bounce: btn_raw[3] toggles every 3 cycles for 30 cycles, then holds 1 -> exactly one btn_press[3], after the final edge.
REQ-026 Glitch and release: a 5-cycle high pulse on btn_raw[5] -> no pulse. Hold 1 for 40 cycles, then 0 -> one press, then one release, with btn_level[5] back at 0.
REQ-027 All 9 bits rise in the same cycle -> 9 press pulses in one cycle; press_any high for exactly that cycle.
REQ-028 Reset at cycle 6 of a held press -> outputs 0 during reset; after reset, one press pulse 8..16 cycles later; no release pulse.
REQ-029 Repeat (SCOREBOARD_BTN_REPEAT_EN): hold btn_raw[1] for 20 ticks -> press pulses at HIGH entry, +5, +7, +9 ... ticks. Same stimulus without the macro -> one pulse.
